// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: shared FSM state encoding and default widths for dram_arbiter
package dram_arbiter_pkg;
  localparam int NUM_CORES_DEFAULT = 4;
  localparam int ADDR_W_DEFAULT = 9;
  localparam int DATA_W_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;
endpackage

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: core request/grant bus and memory port bundle; slave = arbiter side, master = cores+memory side
interface dram_arbiter_if
  import dram_arbiter_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic [NUM_CORES-1:0] core_req;
  logic [NUM_CORES-1:0] core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0] core_grant;
  logic [NUM_CORES-1:0] core_done;
  logic [DATA_W-1:0] core_rdata;
  logic mem_write_en;
  logic mem_read_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input core_req, core_we, core_addr, core_wdata, mem_rdata,
    output core_grant, core_done, core_rdata, mem_write_en, mem_read_en, mem_addr, mem_wdata
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_rdata,
    input core_grant, core_done, core_rdata, mem_write_en, mem_read_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dram_arbiter_rr_arbiter.sv
// rr_arbiter: request vector to one-hot grant; round-robin after last when DRAM_ARB_RR_EN, else lowest index wins
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
`ifdef DRAM_ARB_RR_EN
  input  logic [IW-1:0] last,
`endif
  output logic [N-1:0] gnt
);
`ifdef DRAM_ARB_RR_EN
  always_comb begin
    gnt = '0;
    for (int k = 1; k <= N; k++)
      if (gnt == '0 && req[(int'(last) + k) % N]) gnt[(int'(last) + k) % N] = 1'b1;
  end
`else
  assign gnt = req & -req;
`endif
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: IDLE/ISSUE/CAPTURE arbiter giving NUM_CORES cores one 3-cycle memory access at a time; DRAM_ARB_RR_EN selects round-robin
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input logic clk,
  input logic rst,
  dram_arbiter_if.slave bus
);
  state_t state, state_n;
  logic [NUM_CORES-1:0] gnt, win_q;
  logic we_n, we_q, done_q;
  logic [ADDR_W-1:0] addr_n, addr_q;
  logic [DATA_W-1:0] wdata_n, wdata_q, rdata_q;
  wire take = state == IDLE && |bus.core_req;
`ifdef DRAM_ARB_RR_EN
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  logic [IW-1:0] last_q, gnt_idx;
  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) if (gnt[k]) gnt_idx = IW'(k);
  end
  always_ff @(posedge clk)
    if (rst) last_q <= IW'(NUM_CORES - 1);
    else if (take) last_q <= gnt_idx;
  rr_arbiter #(.N(NUM_CORES)) u_arb (.req(bus.core_req), .last(last_q), .gnt(gnt));
`else
  rr_arbiter #(.N(NUM_CORES)) u_arb (.req(bus.core_req), .gnt(gnt));
`endif
  always_comb begin
    we_n = 1'b0;
    addr_n = '0;
    wdata_n = '0;
    for (int k = 0; k < NUM_CORES; k++)
      if (gnt[k]) begin
        we_n = bus.core_we[k];
        addr_n = bus.core_addr[k*ADDR_W +: ADDR_W];
        wdata_n = bus.core_wdata[k*DATA_W +: DATA_W];
      end
  end
  always_comb begin
    state_n = state == IDLE ? (take ? ISSUE : IDLE) : state == ISSUE ? CAPTURE : IDLE;
    bus.core_grant = state == ISSUE ? win_q : '0;
    bus.core_done = done_q ? win_q : '0;
    bus.core_rdata = rdata_q;
    bus.mem_write_en = state == ISSUE && we_q;
    bus.mem_read_en = state == ISSUE && !we_q;
    bus.mem_addr = addr_q;
    bus.mem_wdata = wdata_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      win_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      done_q <= state == CAPTURE;
      if (take) begin
        win_q <= gnt;
        we_q <= we_n;
        addr_q <= addr_n;
        wdata_q <= wdata_n;
      end
      if (state == CAPTURE && !we_q) rdata_q <= bus.mem_rdata;
    end
endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameters: NUM_CORES, default 4, number of requesting cores; ADDR_W, default 9, word address width; DATA_W, default 16, data width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 core_req  input  NUM_CORES  per-core access request level.
REQ-005 core_we  input  NUM_CORES  per-core write select: 1 is write, 0 is read.
REQ-006 core_addr  input  NUM_CORES*ADDR_W  flattened per-core addresses; core i occupies bits [i*ADDR_W +: ADDR_W].
REQ-007 core_wdata  input  NUM_CORES*DATA_W  flattened per-core write data; core i occupies bits [i*DATA_W +: DATA_W].
REQ-008 core_grant  output  NUM_CORES  one-hot, one-cycle pulse marking the accepted core.
REQ-009 core_done  output  NUM_CORES  one-hot, one-cycle pulse marking the completed access.
REQ-010 core_rdata  output  DATA_W  read data shared by all cores; valid while core_done is high.
REQ-011 mem_write_en  output  1  memory write strobe.
REQ-012 mem_read_en  output  1  memory read strobe.
REQ-013 mem_addr  output  ADDR_W  memory address.
REQ-014 mem_wdata  output  DATA_W  data to the memory write port.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid in the cycle after the read strobe.

Function
REQ-016 The block SHALL implement a 3-state FSM: IDLE, ISSUE, CAPTURE.
REQ-017 IDLE, no core_req bit set: stay in IDLE; both memory strobes low.
REQ-018 IDLE, any core_req bit set at the clock edge:
- pick one winner (REQ-027);
- latch the winner's we, addr and wdata;
- go to ISSUE.
REQ-019 ISSUE cycle, exactly one cycle:
- core_grant[winner] = 1;
- mem_addr and mem_wdata = latched values;
- mem_write_en = latched we, mem_read_en = !latched we.
REQ-020 CAPTURE cycle:
- both strobes low;
- mem_addr holds its value;
- on a read, core_rdata <= mem_rdata at the closing edge.
REQ-021 Next IDLE cycle:
- core_done[winner] = 1 for one cycle;
- core_rdata valid (unchanged after a write);
- a new request may be sampled at the end of this same cycle.
REQ-022 Timing and throughput:
- request sampled at edge 0 -> grant in cycle 1 -> done in cycle 3;
- one access per 3 cycles.
REQ-023 A requester SHALL drop core_req by the end of its grant cycle; if core_req is still high in the done cycle, it is treated as a new request.
REQ-024 Changes to core_we, core_addr or core_wdata after the latch edge SHALL have no effect on the access in flight.
REQ-025 At most one memory strobe SHALL be high in any cycle; core_grant and core_done are each zero or one-hot.
REQ-026 A write followed by a read of the same address SHALL return the written data.

Configuration
REQ-027 Macro DRAM_ARB_RR_EN selects the arbitration policy:
- defined: round-robin; search starts at (last_winner+1) mod NUM_CORES; last_winner resets to NUM_CORES-1, so core 0 wins first;
- undefined: fixed priority, lowest index wins; no last_winner register.

Reset
REQ-028 While rst is high at an edge, state SHALL go to IDLE and all of these SHALL be 0:
- core_grant, core_done, core_rdata;
- mem_write_en, mem_read_en, mem_addr, mem_wdata.
REQ-029 Reset during ISSUE or CAPTURE SHALL abort the access, with no done pulse for it; strobes are low from the cycle after the reset edge.

Structure
REQ-030 A shared package/include SHALL hold:
- state encodings IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2;
- default widths ADDR_W=9, DATA_W=16.
REQ-031 The arbitration logic SHALL be one sub-module, rr_arbiter: combinational request vector in -> one-hot grant out, policy fixed by DRAM_ARB_RR_EN.

Verification
REQ-032 Single write: core 1 writes 16'hBEEF to addr 9'd3 -> mem_write_en high, mem_addr=3, mem_wdata=BEEF in the grant cycle; core_done[1] 2 cycles later.
REQ-033 Read-back: core 2 reads addr 3 after REQ-032 -> core_rdata=16'hBEEF with core_done[2], 3 cycles after the request edge.
REQ-034 Contention: cores 0-3 all request, each dropping req on its grant.
- With DRAM_ARB_RR_EN: grant order 0,1,2,3.
- Core 0 re-requests at once: it is served after 3 in RR mode, and immediately without the macro.
REQ-035 Reset mid-access: rst asserted in the ISSUE cycle -> next cycle all outputs 0, no core_done, FSM in IDLE.
REQ-036 Idle bus and late changes:
- core_req=0 for 20 cycles -> no strobes, no grants;
- core_addr changed in the grant cycle -> memory uses the original address.
